// File: rtl/mem_pkg.sv
// Shared encodings for the wait-stated data memory: access sizes, FSM states,
// byte-lane masks and the alignment helpers used by the top and lane_align.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [3:0] LM_NONE = 4'b0000;
    localparam logic [3:0] LM_BYTE = 4'b0001;
    localparam logic [3:0] LM_HALF = 4'b0011;
    localparam logic [3:0] LM_WORD = 4'b1111;

    function automatic logic [3:0] lane_mask(size_e sz, logic [1:0] lane);
        case (sz)
            SZ_BYTE: return LM_BYTE << lane;
            SZ_HALF: return LM_HALF << {lane[1], 1'b0};
            SZ_WORD: return LM_WORD;
            default: return LM_NONE;
        endcase
    endfunction

    function automatic logic misaligned(size_e sz, logic [1:0] lane);
        case (sz)
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != 2'b00);
            SZ_RSVD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_ws_if.sv
// Request/done handshake between the MEM stage (master) and the data memory (slave).
interface data_memory_ws_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/lane_align.sv
// Combinational byte-lane steering: write mask and merged store word, plus the
// lane-selected and extended load value.
module lane_align
    import mem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] wword,
    output logic [31:0] ldata
);
    logic [31:0] wrep;
    logic [31:0] shifted;

    always_comb begin
        wmask = lane_mask(size, lane);

        // Replicate the store data so every lane sees the right bytes; the mask picks.
        case (size)
            SZ_BYTE: wrep = {4{wdata[7:0]}};
            SZ_HALF: wrep = {2{wdata[15:0]}};
            default: wrep = wdata;
        endcase

        wword = word;
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) begin
                wword[8*b +: 8] = wrep[8*b +: 8];
            end
        end

        shifted = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: ldata = sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'b0, shifted[7:0]};
            SZ_HALF: ldata = sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                                      : {16'b0, shifted[15:0]};
            default: ldata = word;
        endcase
    end
endmodule

// File: rtl/data_memory_ws.sv
// Byte-addressable data memory with request/done handshake, alignment and range
// checking, and a configurable number of wait states per access.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for req; request fields latched on accept
//   ST_WAIT | down-counting the wait states, leaves when count hits 1
//   ST_RESP | memory write / read capture, done pulses next cycle
module data_memory_ws
    import mem_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst,
    data_memory_ws_if.slave  bus
);
    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    state_e            state;
    state_e            state_nx;
    logic [3:0]        wait_cnt;
    logic              accept;
    logic              resp;

    logic              we_q;
    logic              sign_ext_q;
    size_e             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              acc_err;
    logic [3:0]        wmask;
    logic [31:0]       wword;
    logic [31:0]       ldata;

    logic              done_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    assign idx     = addr_q[IDX_W+1:2];
    assign lane    = addr_q[1:0];
    assign acc_err = misaligned(size_q, lane) || ((addr_q >> (IDX_W + 2)) != '0);

    lane_align u_lane_align (
        .size     (size_q),
        .lane     (lane),
        .sign_ext (sign_ext_q),
        .word     (mem[idx]),
        .wdata    (wdata_q),
        .wmask    (wmask),
        .wword    (wword),
        .ldata    (ldata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.req) state_nx = (WS != 4'd0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (wait_cnt <= 4'd1) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != ST_IDLE);
        accept   = (state == ST_IDLE) && bus.req;
        resp     = (state == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WS;
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Request fields are only consumed in WAIT/RESP, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q       <= bus.we;
            size_q     <= size_e'(bus.size);
            sign_ext_q <= bus.sign_ext;
            addr_q     <= bus.addr;
            wdata_q    <= bus.wdata;
        end
    end

    // Gating on rst keeps a reset landing on the RESP edge from committing the store.
    always_ff @(posedge clk) begin
        if (!rst && resp && we_q && !acc_err && (wmask != LM_NONE)) begin
            mem[idx] <= wword;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            done_q <= resp;
            err_q  <= resp && acc_err;
            if (resp && !we_q && !acc_err) begin
                rdata_q <= ldata;
            end
        end
    end

    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_data_memory_ws.sv
// Bench for data_memory_ws: two instances (0 and 3 wait states) checked against
// a byte-array reference model with directed and randomized accesses.
module tb_data_memory_ws;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst3;
    logic        req0, req3;
    logic        we_s, sx_s;
    logic [1:0]  sz_s;
    logic [15:0] addr_s;
    logic [31:0] wd_s;
    int          sel;

    data_memory_ws_if #(.ADDR_W(16)) bus0 ();
    data_memory_ws_if #(.ADDR_W(16)) bus3 ();

    assign bus0.req = req0;  assign bus3.req = req3;
    assign bus0.we = we_s;   assign bus3.we = we_s;
    assign bus0.size = sz_s; assign bus3.size = sz_s;
    assign bus0.sign_ext = sx_s; assign bus3.sign_ext = sx_s;
    assign bus0.addr = addr_s;   assign bus3.addr = addr_s;
    assign bus0.wdata = wd_s;    assign bus3.wdata = wd_s;

    data_memory_ws #(.DEPTH(128), .ADDR_W(16), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst0), .bus(bus0));
    data_memory_ws #(.DEPTH(128), .ADDR_W(16), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst3), .bus(bus3));

    logic        busy_m, done_m, err_m;
    logic [31:0] rdata_m;
    assign busy_m  = (sel != 0) ? bus3.busy  : bus0.busy;
    assign done_m  = (sel != 0) ? bus3.done  : bus0.done;
    assign err_m   = (sel != 0) ? bus3.err   : bus0.err;
    assign rdata_m = (sel != 0) ? bus3.rdata : bus0.rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ref_mem [2][512];
    logic [31:0] ref_rd  [2];

    typedef struct packed {
        logic        w;
        logic [1:0]  sz;
        logic        sx;
        logic [15:0] a;
        logic [31:0] wd;
        logic        er;
        logic [31:0] rd;
    } vec_t;

    // Reference: memory as a flat byte array, little-endian, 512 bytes in range.
    task automatic model_access(input int d, input bit w, input logic [1:0] sz, input bit sx,
                                input logic [15:0] a, input logic [31:0] wd,
                                output logic [31:0] exp_rd, output bit exp_er);
        int nb;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_er = (sz == 2'd3) || ((a % nb) != 0) || (a >= 16'd512);
        if (!exp_er) begin
            if (w) begin
                for (int i = 0; i < nb; i++) ref_mem[d][a + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[d][a + i];
                if (sx && nb < 4 && v[8*nb - 1]) begin
                    for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                ref_rd[d] = v;
            end
        end
        exp_rd = ref_rd[d];
    endtask

    task automatic do_access(input int d, input bit w, input logic [1:0] sz, input bit sx,
                             input logic [15:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output bit er, output int lat,
                             output int bcnt, output bit bz, output bit tmo);
        sel = d;
        @(negedge clk);
        we_s = w; sz_s = sz; sx_s = sx; addr_s = a; wd_s = wd;
        if (d == 0) req0 = 1'b1; else req3 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req3 = 1'b0;
        lat = 0; bcnt = 0; tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done_m) begin
                tmo = 1'b0;
                break;
            end
            if (busy_m) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata_m; er = err_m; bz = busy_m;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst3 = 1'b1; req0 = 1'b1; req3 = 1'b1;
        we_s = 1'b0; sx_s = 1'b0; sz_s = 2'b10; addr_s = 16'h0; wd_s = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus0.busy, bus3.busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_wins_busy: got %b required 00", {bus0.busy, bus3.busy});
        end
        @(negedge clk);
        req0 = 1'b0; req3 = 1'b0; rst0 = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus0.busy, bus0.done, bus0.err, bus0.rdata} !== 35'h0) begin
            failures++;
            $display("FAIL reset_outputs_dut0: got busy=%b done=%b err=%b rdata=%h required all 0",
                     bus0.busy, bus0.done, bus0.err, bus0.rdata);
        end
        checks++;
        if ({bus3.busy, bus3.done, bus3.err, bus3.rdata} !== 35'h0) begin
            failures++;
            $display("FAIL reset_outputs_dut3: got busy=%b done=%b err=%b rdata=%h required all 0",
                     bus3.busy, bus3.done, bus3.err, bus3.rdata);
        end
        ref_rd[0] = 32'h0; ref_rd[1] = 32'h0;
    endtask

    task automatic test_init(input int d);
        logic [31:0] rd, erd, wd;
        bit er, eer, bz, tmo;
        int lat, bcnt;
        for (int k = 0; k < 16; k++) begin
            wd = $urandom;
            model_access(d, 1'b1, 2'b10, 1'b0, 16'(4*k), wd, erd, eer);
            do_access(d, 1'b1, 2'b10, 1'b0, 16'(4*k), wd, rd, er, lat, bcnt, bz, tmo);
            checks++;
            if (tmo || er !== eer) begin
                failures++;
                $display("FAIL init_store d=%0d k=%0d: timeout=%b err=%b required err=%b", d, k, tmo, er, eer);
            end
        end
    endtask

    task automatic test_directed();
        vec_t tbl [16];
        logic [31:0] rd, erd;
        bit er, eer, bz, tmo;
        int lat, bcnt;
        tbl[0]  = '{1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h00000000};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 2'b00, 1'b0, 16'h0013, 32'h00000080, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 2'b00, 1'b1, 16'h0013, 32'h0,        1'b0, 32'hFFFFFF80};
        tbl[4]  = '{1'b0, 2'b00, 1'b0, 16'h0013, 32'h0,        1'b0, 32'h00000080};
        tbl[5]  = '{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        1'b0, 32'h80ADBEEF};
        tbl[6]  = '{1'b1, 2'b01, 1'b0, 16'h0012, 32'h00008001, 1'b0, 32'h80ADBEEF};
        tbl[7]  = '{1'b0, 2'b01, 1'b1, 16'h0012, 32'h0,        1'b0, 32'hFFFF8001};
        tbl[8]  = '{1'b0, 2'b01, 1'b1, 16'h0011, 32'h0,        1'b1, 32'hFFFF8001};
        tbl[9]  = '{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        1'b0, 32'h8001BEEF};
        tbl[10] = '{1'b0, 2'b10, 1'b0, 16'h0200, 32'h0,        1'b1, 32'h8001BEEF};
        tbl[11] = '{1'b1, 2'b11, 1'b0, 16'h0010, 32'h12345678, 1'b1, 32'h8001BEEF};
        tbl[12] = '{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        1'b0, 32'h8001BEEF};
        tbl[13] = '{1'b0, 2'b01, 1'b0, 16'h0010, 32'h0,        1'b0, 32'h0000BEEF};
        tbl[14] = '{1'b1, 2'b00, 1'b0, 16'h0011, 32'h000055AA, 1'b0, 32'h0000BEEF};
        tbl[15] = '{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        1'b0, 32'h8001AAEF};
        // rdata is not touched by stores, so entry 0 still shows the post-reset 0.
        for (int k = 0; k < 16; k++) begin
            model_access(0, tbl[k].w, tbl[k].sz, tbl[k].sx, tbl[k].a, tbl[k].wd, erd, eer);
            do_access(0, tbl[k].w, tbl[k].sz, tbl[k].sx, tbl[k].a, tbl[k].wd, rd, er, lat, bcnt, bz, tmo);
            checks++;
            if (tmo || lat != 1 || bcnt != 1 || bz !== 1'b0) begin
                failures++;
                $display("FAIL directed_timing k=%0d: timeout=%b latency=%0d busy_cycles=%0d busy_at_done=%b required 0/1/1/0",
                         k, tmo, lat, bcnt, bz);
            end
            checks++;
            if (er !== tbl[k].er || rd !== tbl[k].rd) begin
                failures++;
                $display("FAIL directed_data k=%0d: got err=%b rdata=%h required err=%b rdata=%h",
                         k, er, rd, tbl[k].er, tbl[k].rd);
            end
        end
    endtask

    task automatic test_ignore_req();
        logic [31:0] rd, erd;
        bit er, eer, bz, tmo;
        int lat, bcnt, n_done, first;
        sel = 1;
        model_access(1, 1'b0, 2'b10, 1'b0, 16'h0030, 32'h0, erd, eer);
        @(negedge clk);
        we_s = 1'b0; sz_s = 2'b10; sx_s = 1'b0; addr_s = 16'h0030; wd_s = 32'h0;
        req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        n_done = 0; first = -1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) begin
                we_s = 1'b1; addr_s = 16'h0034; wd_s = 32'hCAFEF00D; req3 = 1'b1;
            end else begin
                req3 = 1'b0;
            end
            @(posedge clk); #1;
            if (bus3.done) begin
                n_done++;
                if (first < 0) begin
                    first = i;
                    rd = bus3.rdata;
                end
            end
        end
        checks++;
        if (n_done != 1 || first != 4) begin
            failures++;
            $display("FAIL ignore_req_done: got %0d dones first at edge +%0d required 1 at +4", n_done, first);
        end
        checks++;
        if (rd !== erd) begin
            failures++;
            $display("FAIL ignore_req_rdata: got %h required %h", rd, erd);
        end
        model_access(1, 1'b0, 2'b10, 1'b0, 16'h0034, 32'h0, erd, eer);
        do_access(1, 1'b0, 2'b10, 1'b0, 16'h0034, 32'h0, rd, er, lat, bcnt, bz, tmo);
        checks++;
        if (tmo || er !== 1'b0 || rd !== erd) begin
            failures++;
            $display("FAIL ignore_req_no_write: timeout=%b err=%b rdata=%h required err=0 rdata=%h", tmo, er, rd, erd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, erd;
        bit er, eer, bz, tmo;
        int lat, bcnt, n_done;
        sel = 1;
        @(negedge clk);
        we_s = 1'b1; sz_s = 2'b10; sx_s = 1'b0; addr_s = 16'h0020; wd_s = 32'h0BADF00D;
        req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        n_done = 0;
        @(posedge clk); #1;
        if (bus3.done) n_done++;
        @(negedge clk);
        rst3 = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus3.done) n_done++;
        end
        @(negedge clk);
        rst3 = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus3.done) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d dones required 0", n_done);
        end
        checks++;
        if ({bus3.busy, bus3.done, bus3.err, bus3.rdata} !== 35'h0) begin
            failures++;
            $display("FAIL abort_outputs: got busy=%b done=%b err=%b rdata=%h required all 0",
                     bus3.busy, bus3.done, bus3.err, bus3.rdata);
        end
        ref_rd[1] = 32'h0;
        model_access(1, 1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, erd, eer);
        do_access(1, 1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, rd, er, lat, bcnt, bz, tmo);
        checks++;
        if (tmo || er !== 1'b0 || rd !== erd) begin
            failures++;
            $display("FAIL abort_pre_value: timeout=%b err=%b rdata=%h required err=0 rdata=%h", tmo, er, rd, erd);
        end
    endtask

    task automatic test_random(input int d, input int n);
        logic [31:0] rd, erd, wd;
        logic [15:0] a;
        logic [1:0] sz;
        bit er, eer, bz, tmo, w, sx;
        int lat, bcnt, r, ws;
        ws = (d != 0) ? 3 : 0;
        for (int k = 0; k < n; k++) begin
            w  = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            a  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(512, 65535)) : 16'($urandom_range(0, 63));
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) @(posedge clk);
            model_access(d, w, sz, sx, a, wd, erd, eer);
            do_access(d, w, sz, sx, a, wd, rd, er, lat, bcnt, bz, tmo);
            checks++;
            if (tmo || lat != 1 + ws || bcnt != 1 + ws || bz !== 1'b0) begin
                failures++;
                $display("FAIL random_timing d=%0d k=%0d: timeout=%b latency=%0d busy_cycles=%0d busy_at_done=%b required latency=busy_cycles=%0d",
                         d, k, tmo, lat, bcnt, bz, 1 + ws);
            end
            checks++;
            if (er !== eer || rd !== erd) begin
                failures++;
                $display("FAIL random_data d=%0d k=%0d we=%b size=%0d sx=%b addr=%h: got err=%b rdata=%h required err=%b rdata=%h",
                         d, k, w, sz, sx, a, er, rd, eer, erd);
            end
        end
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_init(0);
        test_init(1);
        test_directed();
        test_ignore_req();
        test_abort();
        test_random(0, 80);
        test_random(1, 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
